scope_mem_arbiter: RTL and testbench

Single-port sample-RAM arbiter between the ADC capture writer and the HDMI trace renderer. Grants the renderer priority with a bounded-starvation slot for capture, and freezes capture after a complete record until the next vertical sync so each displayed frame shows one coherent acquisition. Sits between the capture front end, the sample BRAM and the pixel pipeline clocked by `pixclk`.

---
 rtl/scope_pkg.sv | 17 +
 rtl/edge_rise.sv | 28 ++
 rtl/scope_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_scope_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scope_pkg
// Purpose  : Capture-state encoding and default sample geometry shared by the
//            capture, arbiter and renderer blocks.
// Revision : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 8;

    localparam logic c_FILL = 1'b0;
    localparam logic c_FULL = 1'b1;

endpackage : scope_pkg
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module   : edge_rise
// Purpose  : Registered rising-edge detector; rise is high for the cycle in
//            which d is 1 and its registered copy is still 0.
// Revision : 1.0 - initial release
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign rise = d & ~r_q;

endmodule : edge_rise
`default_nettype wire

// File: rtl/scope_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scope_mem_arbiter
// Purpose  : Single-port sample-RAM arbiter: renderer reads have priority,
//            capture writes get a bounded-starvation slot, and capture freezes
//            after a full record until the next vertical sync.
// Revision : 1.0 - initial release
// ============================================================================
module scope_mem_arbiter
    import scope_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              vsync_i,
    output logic              frame_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_STARVE = 4'(MAX_STARVE);

    logic       r_state;
    logic       w_state_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    logic       w_vsync_rise;
    logic       w_fill;
    logic       w_force_wr;
    logic       w_wr_hs;
    logic       w_rd_hs;
    logic       r_rd_pend;

    edge_rise u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (vsync_i),
        .rise (w_vsync_rise)
    );

    // Capture FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM: next state; a vsync edge while filling is dropped, not held
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FILL:  if (w_wr_hs && wr_last) w_state_nxt = c_FULL;
            c_FULL:  if (w_vsync_rise)       w_state_nxt = c_FILL;
            default: w_state_nxt = c_FILL;
        endcase
    end

    // Capture FSM: outputs
    always_comb begin
        w_fill      = (r_state == c_FILL);
        frame_ready = (r_state == c_FULL);
    end

    // Grants; at most one of the two handshakes can complete in a cycle
    always_comb begin
        w_force_wr = w_fill & wr_valid & (r_starve == c_MAX_STARVE);
        rd_ready   = ~rst & ~w_force_wr;
        wr_ready   = ~rst & w_fill & (~rd_valid | w_force_wr);
        w_wr_hs    = wr_valid & wr_ready;
        w_rd_hs    = rd_valid & rd_ready;
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_wr_hs || !wr_valid || !w_fill) begin
            w_starve_nxt = 4'd0;
        end else if (w_rd_hs && (r_starve != c_MAX_STARVE)) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else begin
            r_starve <= w_starve_nxt;
        end
    end

    // RAM port: one registered command per accepted handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= w_wr_hs | w_rd_hs;
            mem_we <= w_wr_hs;
            if (w_wr_hs) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (w_rd_hs) begin
                mem_addr <= rd_addr;
            end
        end
    end

    // The RAM answers during the mem_en cycle; capture it on the closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend     <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            r_rd_pend     <= w_rd_hs;
            rd_data_valid <= r_rd_pend;
            if (r_rd_pend) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule : scope_mem_arbiter
`default_nettype wire

// File: tb/tb_scope_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scope_mem_arbiter
// Purpose  : Self-checking bench for scope_mem_arbiter with a behavioural
//            reference model and a simple sample-RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scope_mem_arbiter;

    localparam int c_AW = 10;
    localparam int c_DW = 8;
    localparam int c_MS = 4;

    logic            clk;
    logic            rst;
    logic            wr_valid;
    logic [c_AW-1:0] wr_addr;
    logic [c_DW-1:0] wr_data;
    logic            wr_last;
    logic            wr_ready;
    logic            rd_valid;
    logic [c_AW-1:0] rd_addr;
    logic            rd_ready;
    logic            rd_data_valid;
    logic [c_DW-1:0] rd_data;
    logic            vsync_i;
    logic            frame_ready;
    logic            mem_en;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    scope_mem_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .MAX_STARVE(c_MS)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .vsync_i(vsync_i), .frame_ready(frame_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM: data is presented while the registered command is on the port
    logic [c_DW-1:0] ram [0:(1<<c_AW)-1];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Reference model: what each registered output should show after an edge
    bit              m_full;
    int              m_starve;
    bit              m_vprev;
    bit              e_en, e_we, e_rdv, e_rdk;
    logic [c_AW-1:0] e_addr;
    logic [c_DW-1:0] e_wdata, e_rdata;
    logic [c_DW-1:0] ref_ram [int];

    task automatic model_reset();
        m_full = 0; m_starve = 0; m_vprev = 0;
        e_en = 0; e_we = 0; e_rdv = 0; e_rdk = 1;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic idle();
        wr_valid = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
        rd_valid = 0; rd_addr = '0;
    endtask

    task automatic tick();
        bit fw, whs, rhs, rise;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            fw   = !m_full && wr_valid && (m_starve == c_MS);
            whs  = wr_valid && !m_full && (!rd_valid || fw);
            rhs  = rd_valid && !fw;
            rise = vsync_i && !m_vprev;
            e_rdv = e_en && !e_we;
            if (e_rdv) begin
                e_rdk = ref_ram.exists(int'(e_addr));
                if (e_rdk) e_rdata = ref_ram[int'(e_addr)];
            end
            e_en = whs || rhs;
            e_we = whs;
            if (whs) begin
                e_addr = wr_addr; e_wdata = wr_data;
                ref_ram[int'(wr_addr)] = wr_data;
            end else if (rhs) begin
                e_addr = rd_addr;
            end
            if (whs || !wr_valid || m_full) m_starve = 0;
            else if (rhs && m_starve < c_MS) m_starve++;
            if (!m_full && whs && wr_last) m_full = 1;
            else if (m_full && rise) m_full = 0;
            m_vprev = vsync_i;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; vsync_i = 0; idle(); model_reset();
        rd_valid = 1; wr_valid = 1;
        #2;
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
        idle();
        tick(); tick();
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem got %b/%b/%h/%h exp 0", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if ({rd_data_valid, rd_data, frame_ready} !== '0) begin errors++; $display("FAIL reset_rd got %b/%h fr %b exp 0", rd_data_valid, rd_data, frame_ready); end
        rst = 0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_wr_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_write_only();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_addr = c_AW'(i); wr_data = c_DW'(8'h10 + i); wr_last = (i == 3);
            #1;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wo_wr_ready[%0d] got %b exp 1", i, wr_ready); end
            tick();
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== c_AW'(i) || mem_wdata !== c_DW'(8'h10 + i)) begin
                errors++; $display("FAIL wo_mem[%0d] got en%b we%b a%h d%h exp en1 we1 a%h d%h",
                                   i, mem_en, mem_we, mem_addr, mem_wdata, i, 8'h10 + i);
            end
        end
        wr_last = 0; wr_addr = 10'd7;
        #1;
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL wo_frame_ready got %b exp 1", frame_ready); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wo_full_wr_ready got %b exp 0", wr_ready); end
        tick();
        checks++; if (mem_en !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL wo_blocked got en%b rdy%b exp 0 0", mem_en, wr_ready); end
    endtask

    task automatic test_frame_hold();
        wr_valid = 0;
        vsync_i = 1;
        #1;
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL fh_before_edge got %b exp 1", frame_ready); end
        tick();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL fh_after_edge got %b exp 0", frame_ready); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fh_wr_ready got %b exp 1", wr_ready); end
        tick(); vsync_i = 0; tick(); vsync_i = 1; tick(); vsync_i = 0; tick();
        checks++; if (frame_ready !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL fh_fill_vsync got fr%b rdy%b exp 0 1", frame_ready, wr_ready); end
    endtask

    task automatic test_read_latency();
        wr_valid = 1; wr_addr = 10'd5; wr_data = 8'hA5; wr_last = 0;
        tick(); idle(); tick();
        rd_valid = 1; rd_addr = 10'd5;
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rl_rd_ready got %b exp 1", rd_ready); end
        tick(); idle();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5) begin errors++; $display("FAIL rl_mem got en%b we%b a%h exp 1 0 5", mem_en, mem_we, mem_addr); end
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rl_early_valid got %b exp 0", rd_data_valid); end
        tick();
        checks++; if (rd_data_valid !== 1'b1 || rd_data !== 8'hA5) begin errors++; $display("FAIL rl_data got v%b d%h exp 1 a5", rd_data_valid, rd_data); end
        tick();
        checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rl_single_strobe got %b exp 0", rd_data_valid); end
    endtask

    task automatic test_starvation();
        wr_valid = 1; rd_valid = 1; wr_last = 0;
        for (int k = 0; k < 15; k++) begin
            wr_addr = c_AW'(100 + k); wr_data = 8'($urandom); rd_addr = c_AW'($urandom_range(0, 3));
            #1;
            checks++;
            if (rd_ready !== (k % 5 != 4) || wr_ready !== (k % 5 == 4)) begin
                errors++; $display("FAIL starve[%0d] got rd%b wr%b exp rd%b wr%b", k, rd_ready, wr_ready, k % 5 != 4, k % 5 == 4);
            end
            tick();
        end
        idle(); tick(); tick();
    endtask

    task automatic test_simultaneous();
        wr_valid = 1; wr_addr = 10'd9; wr_data = 8'h5A; wr_last = 1; vsync_i = 1;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL sim_wr_ready got %b exp 1", wr_ready); end
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL sim_hold[%0d] got %b exp 1", k, frame_ready); end
            tick();
        end
        vsync_i = 0; tick(); vsync_i = 1; tick();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL sim_release got %b exp 0", frame_ready); end
        vsync_i = 0; tick();
    endtask

    task automatic test_reset_mid_read();
        rd_valid = 1; rd_addr = 10'd5;
        tick(); idle();
        rst = 1; model_reset();
        #1;
        checks++; if (mem_en !== 1'b0 || rd_data_valid !== 1'b0) begin errors++; $display("FAIL rmr_cancel got en%b v%b exp 0 0", mem_en, rd_data_valid); end
        tick();
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, rd_data_valid, rd_data, frame_ready} !== '0) begin
            errors++; $display("FAIL rmr_outputs got en%b we%b a%h d%h v%b rd%h fr%b exp all 0", mem_en, mem_we, mem_addr, mem_wdata, rd_data_valid, rd_data, frame_ready);
        end
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rmr_stale[%0d] got %b exp 0", k, rd_data_valid); end
        end
        checks++; if (frame_ready !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rmr_fill got fr%b rdy%b exp 0 1", frame_ready, wr_ready); end
    endtask

    task automatic test_random();
        bit fw, x_rr, x_wr;
        for (int n = 0; n < 600; n++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            rd_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = c_AW'($urandom_range(0, 15));
            rd_addr  = c_AW'($urandom_range(0, 15));
            wr_data  = 8'($urandom);
            wr_last  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) vsync_i = ~vsync_i;
            #1;
            fw   = !m_full && wr_valid && (m_starve == c_MS);
            x_rr = !fw;
            x_wr = !m_full && (!rd_valid || fw);
            checks++; if (rd_ready !== x_rr || wr_ready !== x_wr) begin errors++; $display("FAIL rnd_ready[%0d] got rd%b wr%b exp rd%b wr%b", n, rd_ready, wr_ready, x_rr, x_wr); end
            checks++; if (mem_en !== e_en || (e_en && (mem_we !== e_we || mem_addr !== e_addr))) begin
                errors++; $display("FAIL rnd_mem[%0d] got en%b we%b a%h exp en%b we%b a%h", n, mem_en, mem_we, mem_addr, e_en, e_we, e_addr);
            end
            checks++; if (e_en && e_we && mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", n, mem_wdata, e_wdata); end
            checks++; if (rd_data_valid !== e_rdv || (e_rdv && e_rdk && rd_data !== e_rdata)) begin
                errors++; $display("FAIL rnd_rdata[%0d] got v%b d%h exp v%b d%h", n, rd_data_valid, rd_data, e_rdv, e_rdata);
            end
            checks++; if (frame_ready !== m_full) begin errors++; $display("FAIL rnd_frame_ready[%0d] got %b exp %b", n, frame_ready, m_full); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_frame_hold();
        test_read_latency();
        test_starvation();
        test_simultaneous();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_scope_mem_arbiter
`default_nettype wire
